// File: rtl/data_ram_responder.sv
// Word-wide data RAM responder for the CPU load/store port with programmable stall cycles.
// Optional DRAM_ALIGN_CHECK_EN adds an err output that flags and suppresses illegal store byte enables.
module data_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
`ifdef DRAM_ALIGN_CHECK_EN
  output logic        err,
`endif
  output logic        ready
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [IdxW-1:0]   idx_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic              ready_q;

  logic              accept, go_resp;
  logic              req_we;
  logic [IdxW-1:0]   req_idx;
  logic [3:0]        req_sel;
  logic [31:0]       req_wdata;
  logic              legal;
  logic              mem_wr;

  logic [31:0]       mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ce) begin
          accept = 1'b1;
          cnt_d  = 4'd0;
          if (WAIT_STATES == 0) begin
            go_resp = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          go_resp = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the response edge is the accepting edge, so use the live request.
  always_comb begin
    req_we    = (state_q == StIdle) ? we : we_q;
    req_idx   = (state_q == StIdle) ? addr[IdxW+1:2] : idx_q;
    req_sel   = (state_q == StIdle) ? sel : sel_q;
    req_wdata = (state_q == StIdle) ? data_i : wdata_q;
  end

`ifdef DRAM_ALIGN_CHECK_EN
  always_comb begin
    legal = 1'b0;
    case (req_sel)
      4'b1111, 4'b1100, 4'b0011,
      4'b1000, 4'b0100, 4'b0010, 4'b0001: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end
`else
  assign legal = 1'b1;
`endif

  // rst gating keeps a store from landing while reset is held.
  assign mem_wr = go_resp & req_we & legal & rst;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= go_resp;
      if (accept) begin
        we_q    <= we;
        idx_q   <= addr[IdxW+1:2];
        sel_q   <= sel;
        wdata_q <= data_i;
      end
      if (go_resp && !req_we) data_q <= mem[req_idx];
    end
  end

`ifdef DRAM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= go_resp & req_we & ~legal;
    end
  end
  assign err = err_q;
`endif

  assign data_o = data_q;
  assign ready  = ready_q;

endmodule
